// File: rtl/fifo_uart_tx.sv
// FIFO read-side UART transmitter: pops a byte, serialises start/8 data LSB-first/stop frame.
// Optional even parity bit between data and stop when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_EN,
  input  logic       i_EMPTY,
  input  logic [7:0] i_RD_DATA,
  output logic       o_RD,
  output logic       o_TX,
  output logic       o_BUSY,
  output logic       o_DONE
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StStop   = 3'd3;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam logic [2:0] StParity = 3'd4;
`endif

  localparam logic [15:0] BaudMax = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  StopMax = 3'(STOP_BITS - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        baud_end;
`ifdef FIFO_UART_TX_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign baud_end = (baud_q == BaudMax);

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    baud_d   = baud_q;
    tx_d     = 1'b1;
    o_RD     = 1'b0;
    o_DONE   = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      StIdle: begin
        // Reset wins over a pending pop so no byte is lost to a discarded frame.
        if (i_EN && !i_EMPTY && !i_RST) begin
          o_RD    = 1'b1;
          shift_d = i_RD_DATA;
          state_d = StStart;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_d = ^i_RD_DATA;
`endif
        end
      end
      StStart: begin
        if (baud_end) state_d = StData;
      end
      StData: begin
        if (baud_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d = 3'd0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      StParity: begin
        if (baud_end) state_d = StStop;
      end
`endif
      StStop: begin
        if (baud_end) begin
          if (bit_q == StopMax) begin
            o_DONE  = 1'b1;
            bit_d   = 3'd0;
            state_d = StIdle;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        bit_d   = 3'd0;
      end
    endcase

    if (state_d != state_q || state_q == StIdle) begin
      baud_d = 16'd0;
    end else if (baud_end) begin
      baud_d = 16'd0;
    end else begin
      baud_d = baud_q + 16'd1;
    end

    // Line level is registered from next-state values so o_TX is glitch-free.
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      StParity: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q  <= StIdle;
      baud_q   <= 16'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign o_TX   = tx_q;
  assign o_BUSY = (state_q != StIdle);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx at CLKS_PER_BIT=4, STOP_BITS=1 with a queue-based FIFO model.
module tb_fifo_uart_tx;

  localparam int unsigned C = 4;
  localparam int unsigned S = 1;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam int unsigned PERIOD = 1 + (10 + S - 1 + PAR) * C;

  logic       clk = 1'b0;
  logic       rst, en, empty;
  logic [7:0] rd_data;
  logic       rd, tx, busy, done;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLKS_PER_BIT(C),
    .STOP_BITS   (S)
  ) dut (
    .i_CLK    (clk),
    .i_RST    (rst),
    .i_EN     (en),
    .i_EMPTY  (empty),
    .i_RD_DATA(rd_data),
    .o_RD     (rd),
    .o_TX     (tx),
    .o_BUSY   (busy),
    .o_DONE   (done)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int last_pop = 0;
  int period = 0;
  logic [7:0] fifo[$];
  logic rd_s, tx_s, busy_s, done_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive FIFO model, sample outputs mid-low-phase, pop on the edge if o_RD was high.
  task automatic step();
    empty   = (fifo.size() == 0);
    rd_data = empty ? 8'h3C : fifo[0];
    #1;
    rd_s   = rd;
    tx_s   = tx;
    busy_s = busy;
    done_s = done;
    @(posedge clk);
    cyc++;
    if (rd_s) begin
      rd_cnt++;
      period   = cyc - last_pop;
      last_pop = cyc;
      if (fifo.size() > 0) void'(fifo.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input logic exp_rd);
    step();
    chk(tag, {28'd0, tx_s, busy_s, done_s, rd_s}, {28'd0, 1'b1, 1'b0, 1'b0, exp_rd});
  endtask

  // Checks every cycle of one frame; {tx,busy,done,rd} packed into one comparison.
  task automatic frame(input logic [7:0] exp, input logic par, input string tag, input int en_drop);
    int   nbits = 9 + PAR + S;
    int   n = 0;
    logic ebit;
    for (int b = 0; b < nbits; b++) begin
      for (int k = 0; k < C; k++) begin
        if (n == en_drop) en = 1'b0;
        step();
        n++;
        if (b == 0) ebit = 1'b0;
        else if (b <= 8) ebit = exp[b-1];
        else if (PAR == 1 && b == 9) ebit = par;
        else ebit = 1'b1;
        chk($sformatf("%s b%0d k%0d", tag, b, k), {28'd0, tx_s, busy_s, done_s, rd_s},
            {28'd0, ebit, 1'b1, (b == nbits - 1 && k == C - 1), 1'b0});
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    step();
    step();
    chk("t1 in reset", {29'd0, tx_s, busy_s, rd_s}, {29'd0, 3'b100});
    rst = 1'b0;
    repeat (20) idle("t1 idle", 1'b0);

    // Single byte; i_RD_DATA goes to 8'h3C after the pop and must be ignored.
    rd_cnt = 0;
    fifo.push_back(8'hAF);
    idle("t2 pop", 1'b1);
    frame(8'hAF, 1'b0, "t2 AF", -1);
    idle("t2 after", 1'b0);
    chk("t2 rd count", rd_cnt, 1);

    rd_cnt = 0;
    fifo.push_back(8'hBA);
    fifo.push_back(8'h5A);
    fifo.push_back(8'h41);
    idle("t3 pop0", 1'b1);
    frame(8'hBA, 1'b1, "t3 BA", -1);
    idle("t3 pop1", 1'b1);
    chk("t3 period1", period, PERIOD);
    frame(8'h5A, 1'b0, "t3 5A", -1);
    idle("t3 pop2", 1'b1);
    chk("t3 period2", period, PERIOD);
    frame(8'h41, 1'b0, "t3 41", -1);
    idle("t3 after", 1'b0);
    chk("t3 rd count", rd_cnt, 3);

    rd_cnt = 0;
    fifo.push_back(8'h50);
    fifo.push_back(8'h12);
    idle("t4 pop0", 1'b1);
    frame(8'h50, 1'b0, "t4 50", 20);
    repeat (8) idle("t4 gated", 1'b0);
    chk("t4 rd count gated", rd_cnt, 1);
    en = 1'b1;
    idle("t4 pop1", 1'b1);
    frame(8'h12, 1'b0, "t4 12", -1);
    idle("t4 after", 1'b0);

    // Reset during data bit 3 of 8'hFC, with 8'hEE already at the FIFO head.
    fifo.push_back(8'hFC);
    idle("t5 pop", 1'b1);
    repeat (C + 3 * C + 1) step();
    chk("t5 bit3", {30'd0, tx_s, busy_s}, {30'd0, 2'b11});
    fifo.push_back(8'hEE);
    rst = 1'b1;
    step();
    chk("t5 rd in reset", {31'd0, rd_s}, 32'd0);
    rst = 1'b0;
    step();
    chk("t5 after reset", {29'd0, tx_s, busy_s, rd_s}, {29'd0, 3'b101});
    frame(8'hEE, 1'b0, "t5 EE", -1);
    idle("t5 after", 1'b0);

    rd_cnt = 0;
    fifo.push_back(8'hAF);
    fifo.push_back(8'h41);
    fifo.push_back(8'h12);
    fifo.push_back(8'h01);
    idle("t6 pop0", 1'b1);
    frame(8'hAF, 1'b0, "t6 AF", -1);
    idle("t6 pop1", 1'b1);
    chk("t6 period1", period, PERIOD);
    frame(8'h41, 1'b0, "t6 41", -1);
    idle("t6 pop2", 1'b1);
    chk("t6 period2", period, PERIOD);
    frame(8'h12, 1'b0, "t6 12", -1);
    idle("t6 pop3", 1'b1);
    chk("t6 period3", period, PERIOD);
    frame(8'h01, 1'b1, "t6 01", -1);
    idle("t6 after", 1'b0);
    chk("t6 rd count", rd_cnt, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
